// File: rtl/modn_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | modn_counter : modulo-MOD up/down counter, wrap or saturate, BCD  |
// | Revision 1.0 : initial release                                    |
// +------------------------------------------------------------------+
module modn_counter #(
  parameter int MOD = 60,
  parameter int W   = 7,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         carry,
  output logic [3:0]   tens,
  output logic [3:0]   ones,
  output logic         load_err
);

  generate
    if ((MOD < 2) || (MOD > 100)) begin : g_bad_mod
      $error("modn_counter: MOD must be in 2..100");
    end
    if ((2 ** W) < MOD) begin : g_bad_width
      $error("modn_counter: W too narrow for MOD");
    end
  endgenerate

  localparam logic [W-1:0] C_LAST = W'(MOD - 1);
  localparam bit           C_SAT  = (SAT != 0);

  logic [W-1:0] count_q, count_d;
  logic         load_err_q, load_err_d;
  logic         w_at_term;
  logic [7:0]   w_val;

  assign w_at_term = up ? (count_q == C_LAST) : (count_q == '0);

  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_val > C_LAST) begin
        count_d    = C_LAST;
        load_err_d = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (en) begin
      if (up) begin
        if (w_at_term) count_d = C_SAT ? C_LAST : '0;
        else           count_d = count_q + 1'b1;
      end else begin
        if (w_at_term) count_d = C_SAT ? '0 : C_LAST;
        else           count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  // count never exceeds 99, so an 8-bit view is enough for the BCD split
  assign w_val    = 8'(count_q);
  assign tens     = 4'(w_val / 8'd10);
  assign ones     = 4'(w_val % 8'd10);
  assign count    = count_q;
  assign load_err = load_err_q;
  assign carry    = en & ~clr & ~load & w_at_term;

endmodule
`default_nettype wire

// File: tb/tb_modn_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_modn_counter : wrap and saturate instances vs arithmetic model |
// | Revision 1.0 : initial release                                    |
// +------------------------------------------------------------------+
module tb_modn_counter;

  localparam int C_MOD = 60;
  localparam int C_W   = 7;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [C_W-1:0] load_val = '0;

  logic [C_W-1:0] count0, count1;
  logic           carry0, carry1, err0, err1;
  logic [3:0]     tens0, ones0, tens1, ones1;

  int m_cnt [2];
  int m_err [2];
  int n_chk  = 0;
  int n_pass = 0;
  int n_car  = 0;

  always #5 clk = ~clk;

  modn_counter #(.MOD(C_MOD), .W(C_W), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count0), .carry(carry0), .tens(tens0),
    .ones(ones0), .load_err(err0)
  );

  modn_counter #(.MOD(C_MOD), .W(C_W), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count1), .carry(carry1), .tens(tens1),
    .ones(ones1), .load_err(err1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_carry(input int c);
    if (!en || clr || load) return 0;
    return up ? int'(c == C_MOD - 1) : int'(c == 0);
  endfunction

  // Next value from the stated rules: modular arithmetic, or clamping when saturating
  function automatic void model_edge(input int sat, input int lv);
    int c;
    c = m_cnt[sat];
    m_err[sat] = 0;
    if (clr) c = 0;
    else if (load) begin
      if (lv >= C_MOD) begin c = C_MOD - 1; m_err[sat] = 1; end
      else c = lv;
    end else if (en) begin
      if (sat == 0) c = up ? (c + 1) % C_MOD : (c + C_MOD - 1) % C_MOD;
      else          c = up ? ((c + 1 > C_MOD - 1) ? C_MOD - 1 : c + 1)
                           : ((c - 1 < 0) ? 0 : c - 1);
    end
    m_cnt[sat] = c;
  endfunction

  task automatic chk_state();
    int t0, o0, t1, o1;
    t0 = 0; o0 = m_cnt[0];
    while (o0 >= 10) begin o0 -= 10; t0++; end
    t1 = 0; o1 = m_cnt[1];
    while (o1 >= 10) begin o1 -= 10; t1++; end
    chk("wrap.count", int'(count0), m_cnt[0]);
    chk("wrap.load_err", int'(err0), m_err[0]);
    chk("wrap.tens", int'(tens0), t0);
    chk("wrap.ones", int'(ones0), o0);
    chk("sat.count", int'(count1), m_cnt[1]);
    chk("sat.load_err", int'(err1), m_err[1]);
    chk("sat.tens", int'(tens1), t1);
    chk("sat.ones", int'(ones1), o1);
  endtask

  task automatic step(input logic i_en, input logic i_up, input logic i_clr,
                      input logic i_load, input int lv);
    @(negedge clk);
    en = i_en; up = i_up; clr = i_clr; load = i_load; load_val = C_W'(lv);
    #1;
    chk("wrap.carry", int'(carry0), exp_carry(m_cnt[0]));
    chk("sat.carry", int'(carry1), exp_carry(m_cnt[1]));
    if (carry0) n_car++;
    @(posedge clk);
    model_edge(0, lv);
    model_edge(1, lv);
    #1;
    chk_state();
    en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
  endtask

  initial begin
    m_cnt[0] = 0; m_cnt[1] = 0; m_err[0] = 0; m_err[1] = 0;
    #12;
    chk_state();
    @(negedge clk) reset = 1'b0;

    // wrap count: 125 enabled up-steps, two terminal pulses expected
    n_car = 0;
    for (int i = 0; i < 125; i++) step(1, 1, 0, 0, 0);
    chk("wrap.carry_pulses", n_car, 2);
    chk("wrap.after125", int'(count0), 5);

    // down wrap from zero
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("down.wrap", int'(count0), 59);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    chk("down.56", int'(count0), 56);

    // load in and out of range, then the error flag must drop
    step(0, 0, 0, 1, 42);
    step(0, 0, 0, 1, 75);
    step(0, 0, 0, 0, 0);

    // priority clr > load > en
    step(0, 0, 0, 1, 30);
    step(1, 1, 1, 1, 20);
    step(1, 1, 0, 1, 10);
    chk("prio.load_wins", int'(count0), 10);

    // saturation at both ends
    step(0, 0, 0, 1, 59);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0);

    // randomized traffic, including direction changes every cycle
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(15) == 0),
           ($urandom_range(7) == 0), int'($urandom_range(127)));
    end

    // asynchronous reset between edges at count 37
    step(0, 0, 0, 1, 37);
    #2;
    reset = 1'b1; en = 1'b1; up = 1'b0;
    #1;
    m_cnt[0] = 0; m_cnt[1] = 0; m_err[0] = 0; m_err[1] = 0;
    chk_state();
    chk("rst.carry_dn", int'(carry0), 1);
    up = 1'b1;
    #1;
    chk("rst.carry_up", int'(carry0), 0);
    @(negedge clk) reset = 1'b0;
    en = 1'b0; up = 1'b0;
    step(1, 1, 0, 0, 0);
    chk("rst.first_step", int'(count0), 1);

    // reset must also clear a pending load error
    step(0, 0, 0, 1, 99);
    #2;
    reset = 1'b1;
    #1;
    m_cnt[0] = 0; m_cnt[1] = 0; m_err[0] = 0; m_err[1] = 0;
    chk_state();
    @(negedge clk) reset = 1'b0;
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
